// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencing controller for the RV32I core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, owns the imem/dmem
// req/ack handshakes, gates IR/PC/regfile write strobes and traps on illegal
// instructions or bus timeouts.
//
// Optional feature macro: MULTICYCLE_PERF_EN (adds cycle_cnt_o / instret_o).
//
// Ports:
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   run_en_i                  allow a new fetch to start
//   imem_req_o / imem_ack_i   instruction fetch handshake
//   ir_we_o                   instruction register load strobe
//   RegWrite_en_i, MemWrite_en_i, load_i, illegal_i   decoder controls
//   dmem_req_o / dmem_we_o / dmem_ack_i               data access handshake
//   rf_we_o, pc_we_o          register-file and PC write strobes
//   trap_o                    sticky fault flag
//   state_o                   current state code
//   cycle_cnt_o, instret_o    performance counters (MULTICYCLE_PERF_EN only)
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned PERF_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              run_en_i,
  output logic              imem_req_o,
  input  logic              imem_ack_i,
  output logic              ir_we_o,
  input  logic              RegWrite_en_i,
  input  logic              MemWrite_en_i,
  input  logic              load_i,
  input  logic              illegal_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  input  logic              dmem_ack_i,
  output logic              rf_we_o,
  output logic              pc_we_o,
  output logic              trap_o,
  output logic [2:0]        state_o
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt_o,
  output logic [PERF_W-1:0] instret_o
`endif
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned WAIT_W  = 8;

  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd0;
  localparam logic [STATE_W-1:0] ST_DECODE = 3'd1;
  localparam logic [STATE_W-1:0] ST_EXEC   = 3'd2;
  localparam logic [STATE_W-1:0] ST_MEM    = 3'd3;
  localparam logic [STATE_W-1:0] ST_WB     = 3'd4;
  localparam logic [STATE_W-1:0] ST_TRAP   = 3'd7;

  // Elaboration-time parameter range check
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || PERF_W < 1) begin : g_param_check
    $error("multicycle_ctrl: parameter out of range");
  end

  logic [STATE_W-1:0] state_q, state_d;
  logic               pending_q, pending_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [WAIT_W:0]    wait_inc_c;
  logic               waiting_c;
  logic               timeout_c;
  logic               imem_req_c;

  // State register with pending-fetch flag and wait counter
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_FETCH;
      pending_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wait_q    <= wait_d;
    end
  end

  // Next-state logic, including handshake wait tracking and timeout
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    waiting_c  = 1'b0;
    wait_inc_c = {1'b0, wait_q} + (WAIT_W+1)'(1);

    // A wait cycle is one where the active request is high but not acked
    if (state_q == ST_FETCH) begin
      waiting_c = imem_req_c && !imem_ack_i;
    end else if (state_q == ST_MEM) begin
      waiting_c = !dmem_ack_i;
    end
    timeout_c = waiting_c && (wait_inc_c >= (WAIT_W+1)'(TIMEOUT_CYCLES));

    case (state_q)
      ST_FETCH: begin
        if (imem_req_c && imem_ack_i) begin
          state_d = ST_DECODE;
        end else if (timeout_c) begin
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: state_d = illegal_i ? ST_TRAP : ST_EXEC;
      ST_EXEC:   state_d = (load_i || MemWrite_en_i) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (dmem_ack_i) begin
          state_d = MemWrite_en_i ? ST_FETCH : ST_WB;
        end else if (timeout_c) begin
          state_d = ST_TRAP;
        end
      end
      ST_WB:     state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_TRAP;
    endcase

    // Pending keeps the fetch request up once raised, even if run_en drops
    if (state_d != ST_FETCH) begin
      pending_d = 1'b0;
    end else if (state_q == ST_FETCH && imem_req_c) begin
      pending_d = !imem_ack_i;
    end

    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting_c) begin
      wait_d = wait_inc_c[WAIT_W-1:0];
    end else begin
      wait_d = wait_q;
    end
  end

  // Output decode from state, pending and handshake inputs
  always_comb begin
    imem_req_c = 1'b0;
    ir_we_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    trap_o     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_c = run_en_i || pending_q;
        ir_we_o    = imem_req_c && imem_ack_i;
      end
      ST_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = MemWrite_en_i;
        // Stores retire directly from MEM
        pc_we_o    = dmem_ack_i && MemWrite_en_i;
      end
      ST_WB: begin
        rf_we_o = RegWrite_en_i;
        pc_we_o = 1'b1;
      end
      ST_TRAP: trap_o = 1'b1;
      default: ;
    endcase
  end

  assign imem_req_o = imem_req_c;
  assign state_o    = state_q;

`ifdef MULTICYCLE_PERF_EN
  logic [PERF_W-1:0] cycle_cnt_q;
  logic [PERF_W-1:0] instret_q;

  // Free-running cycle and retired-instruction counters, wrapping
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      if (state_q != ST_TRAP) begin
        cycle_cnt_q <= cycle_cnt_q + PERF_W'(1);
      end
      if (pc_we_o) begin
        instret_q <= instret_q + PERF_W'(1);
      end
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instret_o   = instret_q;
`endif

endmodule
